// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the register bank with round-robin write arbiter.
package reg_bank_pkg;
  localparam int DATA_W       = 32;
  localparam int WR_COUNT_W   = 16;
  localparam int N_REQ_DEF    = 4;
  localparam int NUM_REGS_DEF = 8;

  // Priority pointer for the default requester count.
  typedef logic [$clog2(N_REQ_DEF)-1:0] rr_ptr_t;
endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Write-request / read-port bundle between write-back sources and the register bank.
interface reg_bank_arbiter_if
  import reg_bank_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int AW       = $clog2(NUM_REGS)
);
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][AW-1:0]     wr_addr;
  logic [N_REQ-1:0][DATA_W-1:0] wr_data;
  logic [N_REQ-1:0]             gnt;
  logic [AW-1:0]                rd_addr_a;
  logic [DATA_W-1:0]            rd_data_a;
  logic [AW-1:0]                rd_addr_b;
  logic [DATA_W-1:0]            rd_data_b;
  logic [WR_COUNT_W-1:0]        wr_count;

  modport master (
    output req, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  gnt, rd_data_a, rd_data_b, wr_count
  );

  modport slave (
    input  req, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output gnt, rd_data_a, rd_data_b, wr_count
  );
endinterface

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted req scanning from ptr with wrap; ptr moves
// past the winner on every granted edge. gnt is forced low while in reset.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    win
);
  logic [PW-1:0] ptr;
  logic          found;
  int            j;

  // Combinational scan ptr, ptr+1, ... modulo N_REQ; first hit wins.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        win    = PW'(j);
      end
    end
    if (!reset) begin
      gnt = '0;
      win = '0;
    end
  end

  // Priority pointer: advance to the slot after the winner, hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (|gnt)
      ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/reg_bank_arbiter.sv
// Shared 32-bit register bank with one arbitrated write port and two
// combinational read ports. Optional macro REG_BANK_ZERO_REG_EN hardwires
// register 0 to zero (writes to it still consume a grant and count).
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  reg_bank_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [N_REQ-1:0]                gnt;
  logic [PW-1:0]                   win;
  logic                            wr_en;
  logic [AW-1:0]                   wa;
  logic [DATA_W-1:0]               wd;
  logic [WR_COUNT_W-1:0]           wr_count;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .gnt   (gnt),
    .win   (win)
  );

  assign bus.gnt = gnt;
  assign wr_en   = |gnt;
  assign wa      = bus.wr_addr[win];
  assign wd      = bus.wr_data[win];

  // Storage: the winner's data lands on the edge; no same-cycle bypass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      regs <= '0;
`ifdef REG_BANK_ZERO_REG_EN
    else if (wr_en && wa != '0)
`else
    else if (wr_en)
`endif
      regs[wa] <= wd;
  end

  // Completed-write counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wr_count <= '0;
    else if (wr_en)
      wr_count <= wr_count + 1'b1;
  end

  assign bus.wr_count  = wr_count;
  assign bus.rd_data_a = regs[bus.rd_addr_a];
  assign bus.rd_data_b = regs[bus.rd_addr_b];
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (N_REQ=4, NUM_REGS=8).
module tb_reg_bank_arbiter;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  reg_bank_arbiter_if #(.N_REQ(4), .NUM_REGS(8)) bus ();

  reg_bank_arbiter #(.N_REQ(4), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    reset   = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic rd_a(input logic [2:0] a);
    bus.rd_addr_a = a;
    #1;
  endtask

  initial begin
    logic [31:0] zexp;
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.wr_addr[i] = 3'(i);
      bus.wr_data[i] = 32'(i + 10);
    end
    bus.rd_addr_a = 3'd0;
    bus.rd_addr_b = 3'd1;
    #1;
    // Reset state with all requests pending.
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rda", bus.rd_data_a, 32'h0);
    chk("rst_rdb", bus.rd_data_b, 32'h0);
    chk("rst_cnt", 32'(bus.wr_count), 32'h0);
    tick();
    tick();
    chk("rst_hold_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_hold_cnt", 32'(bus.wr_count), 32'h0);

    // Release: round-robin 0,1,2,3,0 with all requesting.
    reset = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(1 << (k % 4)));
      tick();
    end
    bus.req = '0;
    #1;
    chk("idle_gnt", 32'(bus.gnt), 32'h0);
    chk("rr_cnt", 32'(bus.wr_count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      rd_a(3'(i));
      chk($sformatf("rr_reg%0d", i), bus.rd_data_a, 32'(i + 10));
    end
    bus.rd_addr_b = 3'd3;
    #1;
    chk("rr_rdb3", bus.rd_data_b, 32'd13);

    // Single write from requester 2; no bypass before the edge.
    do_reset();
    rd_a(3'd2);
    chk("clr_reg2", bus.rd_data_a, 32'h0);
    chk("clr_cnt", 32'(bus.wr_count), 32'h0);
    bus.wr_addr[2] = 3'd3;
    bus.wr_data[2] = 32'd52;
    bus.req = 4'b0100;
    rd_a(3'd3);
    chk("sw_gnt", 32'(bus.gnt), 32'h4);
    chk("sw_nobypass", bus.rd_data_a, 32'h0);
    tick();
    bus.req = '0;
    #1;
    chk("sw_rd", bus.rd_data_a, 32'd52);
    chk("sw_cnt", 32'(bus.wr_count), 32'd1);

    // Same-address collision from ptr=0: requester 1 then 3.
    do_reset();
    bus.wr_addr[1] = 3'd5;
    bus.wr_data[1] = 32'h0000AAAA;
    bus.wr_addr[3] = 3'd5;
    bus.wr_data[3] = 32'h00005555;
    bus.req = 4'b1010;
    rd_a(3'd5);
    chk("col_gnt1", 32'(bus.gnt), 32'h2);
    tick();
    bus.req = 4'b1000;
    #1;
    chk("col_gnt3", 32'(bus.gnt), 32'h8);
    chk("col_mid", bus.rd_data_a, 32'h0000AAAA);
    tick();
    bus.req = '0;
    #1;
    chk("col_final", bus.rd_data_a, 32'h00005555);
    chk("col_cnt", 32'(bus.wr_count), 32'd2);

    // Register 0 write: discarded only when the zero register is enabled.
    do_reset();
    bus.wr_addr[0] = 3'd0;
    bus.wr_data[0] = 32'hDEADBEEF;
    bus.req = 4'b0001;
    rd_a(3'd0);
`ifdef REG_BANK_ZERO_REG_EN
    zexp = 32'h0;
`else
    zexp = 32'hDEADBEEF;
`endif
    tick();
    bus.req = '0;
    #1;
    chk("r0_rd", bus.rd_data_a, zexp);
    chk("r0_cnt", 32'(bus.wr_count), 32'd1);

    // Reset in the middle of a granted write; ptr must return to 0.
    do_reset();
    bus.wr_addr[0] = 3'd1;
    bus.wr_data[0] = 32'd1;
    bus.req = 4'b0001;
    tick();
    bus.wr_addr[2] = 3'd2;
    bus.wr_data[2] = 32'd77;
    bus.req = 4'b0100;
    rd_a(3'd2);
    chk("mid_gnt", 32'(bus.gnt), 32'h4);
    reset = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_cnt", 32'(bus.wr_count), 32'h0);
    tick();
    chk("mid_rst_reg2", bus.rd_data_a, 32'h0);
    rd_a(3'd1);
    chk("mid_rst_reg1", bus.rd_data_a, 32'h0);
    bus.req = 4'b0101;
    reset = 1'b1;
    #1;
    chk("mid_rel_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = '0;
    #1;
    chk("mid_rel_cnt", 32'(bus.wr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shared 32-bit register bank with a round-robin write arbiter. Up to N_REQ requesters (datapath stages, debug port, exception logic) compete for one write port into NUM_REGS rising-edge 32-bit registers. Two asynchronous read ports serve the datapath. The block sits between the control unit's write-back sources and the register storage, and guarantees one write per cycle with fair access.

## Interface
Parameters:
- N_REQ, 4, number of write requesters (2..8)
- NUM_REGS, 8, number of 32-bit registers (power of two, 2..32)
- AW, $clog2(NUM_REGS), register address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately
- req  input  N_REQ  per-requester write request; bit i is requester i
- wr_addr  input  N_REQ*AW  packed write addresses; slice i belongs to requester i
- wr_data  input  N_REQ*32  packed write data; slice i belongs to requester i
- gnt  output  N_REQ  one-hot grant, combinational from req and priority pointer
- rd_addr_a  input  AW  read port A address
- rd_data_a  output  32  read port A data, combinational from register outputs
- rd_addr_b  input  AW  read port B address
- rd_data_b  output  32  read port B data
- wr_count  output  16  number of completed writes, wraps at 16'hFFFF -> 0

## Operation
- Registers are rising-edge 32-bit flops. All registers are 0 while reset=0.
- Arbitration is round-robin. Priority pointer ptr is in 0..N_REQ-1 and resets to 0.
- The winner is the first asserted req bit scanning ptr, ptr+1, ... with wrap modulo N_REQ.
- gnt is the winner's one-hot bit. gnt=0 when req=0. gnt is never multi-hot.
- On a rising edge with gnt[i]=1:
  - reg[wr_addr_i] <= wr_data_i
  - ptr <= (i+1) mod N_REQ
  - wr_count increments
- With no grant, ptr and wr_count hold.
- Handshake:
  - A requester holds req, wr_addr and wr_data stable until it samples gnt=1 at a rising edge. The transfer completes on that edge.
  - The requester may deassert req or present new data in the following cycle.
  - Deasserting req before a grant is legal. Nothing is written.
- Fairness: a continuously asserting requester is granted within N_REQ cycles.
- Reads return the current register contents. A same-cycle write is not bypassed; the new value is visible after the edge.
- Simultaneous requests to the same address from different requesters are serialized in round-robin order. The last granted value persists.
- Reset mid-operation: registers, ptr and wr_count clear asynchronously, and gnt drops to 0 while reset=0. Pending requests are re-arbitrated from ptr=0 after release.

## Timing
- Write latency: 1 edge from grant to the data being visible on the read ports.
- Read latency: 0 cycles (combinational).
- gnt is valid in the same cycle req is presented, with no registered stage.
- Throughput: 1 write per cycle.
- Reset values: all registers 0, ptr 0, wr_count 0, gnt 0, rd_data_a/b 0.

## Configuration
- REG_BANK_ZERO_REG_EN defined:
  - Register 0 is hardwired to 32'h0. Reads of address 0 return 0.
  - Granted writes to address 0 are discarded but still consume the grant, advance ptr and increment wr_count.
- REG_BANK_ZERO_REG_EN undefined: register 0 is an ordinary storage register.

## Structure
- Shared package reg_bank_pkg holds:
  - DATA_W = 32
  - WR_COUNT_W = 16
  - the default N_REQ and NUM_REGS constants
  - the rr_ptr_t typedef (log2 N_REQ bits)
- One sub-module, rr_arbiter: combinational round-robin pick (req, ptr -> gnt, winner index) plus the ptr update flop.
- The top level holds the register array, the write decoder, the read muxes and wr_count.

## Test plan
- Reset: drive reset=0 with req=4'b1111 -> gnt=0, rd_data_a=rd_data_b=0, wr_count=0. Release reset -> first grant goes to requester 0.
- Single write: req[2]=1, wr_addr_2=3, wr_data_2=52 -> gnt=4'b0100 in the same cycle. After the edge, rd_addr_a=3 gives rd_data_a=52 and wr_count=1.
- Round-robin: req=4'b1111 held for 5 cycles, each requester writing its index+10 to address index -> grants 0,1,2,3,0 in order. Registers 0..3 read 10,11,12,13 and wr_count=5.
- Same-address collision: requesters 1 and 3 both write address 5 (values 0xAAAA and 0x5555) from ptr=0 -> requester 1 wins first, then 3. Final reg[5]=0x5555.
- Zero register (macro defined): requester 0 writes 0xDEADBEEF to address 0 -> rd_data_a=0 after the edge, and wr_count still increments.
- Reset mid-stream: assert reset=0 during a granted write of 77 to address 2 (before the edge) -> reg[2]=0, ptr=0, wr_count=0. After release, requester 0 is granted first.
